// File: rtl/button_debounce.sv
// Per-channel two-flop synchronizer and counter debouncer for active-low push-buttons.
// Presents a clean level to the button PIO plus one-cycle press/release strobes.
module button_debounce #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int INVERT          = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] btn_in,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] press_pulse,
  output logic [WIDTH-1:0] release_pulse
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    IDLE     = 1'b0,
    COUNTING = 1'b1
  } state_e;

  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;
  logic [WIDTH-1:0] w_stable;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1 <= '1;
      r_s2 <= '1;
    end else begin
      r_s1 <= btn_in;
      r_s2 <= r_s1;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    logic [CNT_W-1:0] r_cnt;
    logic             r_stable;
    logic             r_press;
    logic             r_release;
    state_e           w_state;

    // The channel is counting exactly while the synchronized input disagrees with the accepted state.
    assign w_state = (r_s2[i] != r_stable) ? COUNTING : IDLE;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_cnt     <= '0;
        r_stable  <= 1'b1;
        r_press   <= 1'b0;
        r_release <= 1'b0;
      end else begin
        r_press   <= 1'b0;
        r_release <= 1'b0;
        unique case (w_state)
          IDLE: r_cnt <= '0;
          COUNTING: begin
            if (r_cnt == CNT_LAST) begin
              r_stable  <= r_s2[i];
              r_cnt     <= '0;
              r_press   <= ~r_s2[i];
              r_release <= r_s2[i];
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        endcase
      end
    end

    assign w_stable[i]      = r_stable;
    assign press_pulse[i]   = r_press;
    assign release_pulse[i] = r_release;
  end

  assign out_port = (INVERT != 0) ? ~w_stable : w_stable;

endmodule
